// File: rtl/mips_fetch.sv
// mips_fetch: PC owner and single-outstanding imem requester feeding decode; optional FETCH_ALIGN_CHECK_EN.
// Latency: one instruction per 3 cycles with a 1-cycle memory (REQ -> WAIT -> HOLD, no prefetch).
// Backpressure: the fetched entry is held stable in HOLD until inst_ready; no new request while held.
module mips_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_b,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    input  logic        redirect,
    input  logic [1:0]  redirect_sel,
    input  logic        br_taken,
    input  logic [31:0] redir_pc4,
    input  logic [15:0] br_off,
    input  logic [31:0] rs_data,
    input  logic [25:0] jmp_imm,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        fetch_fault,
`endif
    input  logic        halt
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state, state_nxt, resume_st;
    logic [31:0] pc, pc_nxt;
    logic        squash, squash_nxt;
    logic [31:0] inst_nxt, inst_pc_nxt, inst_pc4_nxt;
    logic        redir_act;
    logic [31:0] br_tgt, raw_tgt, tgt, fault_pc;
    logic        tgt_bad, pc_bad, go_fault;

    assign redir_act = redirect && (redirect_sel != 2'b00);
    assign br_tgt    = redir_pc4 + {{14{br_off[15]}}, br_off, 2'b00};
    assign resume_st = halt ? IDLE : REQ;

    always_comb begin
        raw_tgt = redir_pc4;
        case (redirect_sel)
            2'b01:   raw_tgt = br_taken ? br_tgt : redir_pc4;
            2'b10:   raw_tgt = rs_data;
            2'b11:   raw_tgt = {redir_pc4[31:28], jmp_imm, 2'b00};
            default: raw_tgt = redir_pc4;
        endcase
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign tgt     = raw_tgt;
    assign tgt_bad = (raw_tgt[1:0] != 2'b00);
    assign pc_bad  = (pc[1:0] != 2'b00);
`else
    assign tgt     = raw_tgt & 32'hFFFF_FFFC;
    assign tgt_bad = 1'b0;
    assign pc_bad  = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        squash_nxt   = squash;
        inst_nxt     = inst;
        inst_pc_nxt  = inst_pc;
        inst_pc4_nxt = inst_pc4;
        go_fault     = 1'b0;
        fault_pc     = tgt;
        case (state)
            IDLE: begin
                if (redir_act) begin
                    pc_nxt = tgt;
                    if (tgt_bad) go_fault = 1'b1;
                    else         state_nxt = resume_st;
                end else begin
                    state_nxt = resume_st;
                end
            end
            REQ: begin
                // A grant alongside a redirect is still taken; its response gets squashed.
                if (redir_act) begin
                    pc_nxt = tgt;
                    if (imem_gnt) begin
                        state_nxt  = WAIT;
                        squash_nxt = 1'b1;
                    end else if (tgt_bad) begin
                        go_fault = 1'b1;
                    end
                end else if (imem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redir_act) begin
                    pc_nxt = tgt;
                    if (imem_rvalid) begin
                        squash_nxt = 1'b0;
                        if (tgt_bad) go_fault = 1'b1;
                        else         state_nxt = resume_st;
                    end else begin
                        squash_nxt = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (squash) begin
                        squash_nxt = 1'b0;
                        fault_pc   = pc;
                        if (pc_bad) go_fault = 1'b1;
                        else        state_nxt = resume_st;
                    end else begin
                        inst_nxt     = imem_rdata;
                        inst_pc_nxt  = pc;
                        inst_pc4_nxt = pc + 32'd4;
                        pc_nxt       = pc + 32'd4;
                        state_nxt    = HOLD;
                    end
                end
            end
            HOLD: begin
                // Redirect wins over inst_ready: the held instruction is younger and dies.
                if (redir_act) begin
                    pc_nxt = tgt;
                    if (tgt_bad) go_fault = 1'b1;
                    else         state_nxt = resume_st;
                end else if (inst_ready) begin
                    state_nxt = resume_st;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (go_fault) begin
            state_nxt    = HOLD;
            inst_nxt     = 32'h0000_000C;
            inst_pc_nxt  = fault_pc;
            inst_pc4_nxt = fault_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            squash   <= 1'b0;
            inst     <= 32'h0;
            inst_pc  <= RESET_PC;
            inst_pc4 <= RESET_PC + 32'd4;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            squash   <= squash_nxt;
            inst     <= inst_nxt;
            inst_pc  <= inst_pc_nxt;
            inst_pc4 <= inst_pc4_nxt;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_nxt;

    assign fault_nxt   = go_fault || (fault_q && (state_nxt == HOLD));
    assign fetch_fault = fault_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) fault_q <= 1'b0;
        else        fault_q <= fault_nxt;
    end
`endif

    assign imem_req   = (state == REQ);
    assign imem_addr  = pc & 32'hFFFF_FFFC;
    assign inst_valid = (state == HOLD);

endmodule

// File: tb/tb_mips_fetch.sv
// Directed bench for mips_fetch: zero-wait memory responder driven from tick(), hand-computed expectations.
module tb_mips_fetch;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk;
    logic        rst_b;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        redirect;
    logic [1:0]  redirect_sel;
    logic        br_taken;
    logic [31:0] redir_pc4;
    logic [15:0] br_off;
    logic [31:0] rs_data;
    logic [25:0] jmp_imm;
    logic        halt;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    logic auto_rsp;
    int   checks;
    int   fails;

    mips_fetch #(.RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_pc4     (inst_pc4),
        .redirect     (redirect),
        .redirect_sel (redirect_sel),
        .br_taken     (br_taken),
        .redir_pc4    (redir_pc4),
        .br_off       (br_off),
        .rs_data      (rs_data),
        .jmp_imm      (jmp_imm),
`ifdef FETCH_ALIGN_CHECK_EN
        .fetch_fault  (fetch_fault),
`endif
        .halt         (halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Memory answers one cycle after a grant with {BEEF, addr[15:0]}.
    task automatic tick();
        logic        fire;
        logic [31:0] a;
        fire = imem_req && imem_gnt;
        a    = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = fire && auto_rsp;
        imem_rdata  = {16'hBEEF, a[15:0]};
    endtask

    task automatic fetch_one(input logic [31:0] a);
        chk1("f_req", imem_req, 1'b1);
        chk("f_addr", imem_addr, a);
        tick();
        chk1("f_wait_req", imem_req, 1'b0);
        chk1("f_wait_vld", inst_valid, 1'b0);
        tick();
        chk1("f_vld", inst_valid, 1'b1);
        chk("f_inst", inst, {16'hBEEF, a[15:0]});
        chk("f_pc", inst_pc, a);
        chk("f_pc4", inst_pc4, a + 32'd4);
        tick();
    endtask

    task automatic clear_redirect();
        redirect     = 1'b0;
        redirect_sel = 2'b00;
        br_taken     = 1'b0;
    endtask

    initial begin
        checks       = 0;
        fails        = 0;
        rst_b        = 1'b1;
        imem_gnt     = 1'b1;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        inst_ready   = 1'b1;
        redirect     = 1'b0;
        redirect_sel = 2'b00;
        br_taken     = 1'b0;
        redir_pc4    = 32'h0;
        br_off       = 16'h0;
        rs_data      = 32'h0;
        jmp_imm      = 26'h0;
        halt         = 1'b0;
        auto_rsp     = 1'b1;

        #2 rst_b = 1'b0;
        #5;
        chk1("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, RPC);
        chk1("rst_vld", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", inst_pc, RPC);
        chk("rst_pc4", inst_pc4, RPC + 32'd4);
`ifdef FETCH_ALIGN_CHECK_EN
        chk1("rst_fault", fetch_fault, 1'b0);
`endif
        @(posedge clk);
        #1 rst_b = 1'b1;
        chk1("idle_req", imem_req, 1'b0);
        tick();

        // Sequential fetch, three cycles per instruction.
        fetch_one(32'h0040_0000);
        fetch_one(32'h0040_0004);
        fetch_one(32'h0040_0008);

        // Backpressure in HOLD.
        inst_ready = 1'b0;
        chk("bp_addr", imem_addr, 32'h0040_000C);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk1("bp_vld", inst_valid, 1'b1);
            chk("bp_inst", inst, 32'hBEEF_000C);
            chk("bp_pc", inst_pc, 32'h0040_000C);
            chk1("bp_noreq", imem_req, 1'b0);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        chk1("bp_next_req", imem_req, 1'b1);
        chk("bp_next_addr", imem_addr, 32'h0040_0010);

        // Jump redirect while WAIT, response arrives later and is squashed.
        auto_rsp = 1'b0;
        tick();
        redirect     = 1'b1;
        redirect_sel = 2'b11;
        jmp_imm      = 26'h010_0000;
        redir_pc4    = 32'h0040_0008;
        tick();
        clear_redirect();
        chk1("sq_wait_req", imem_req, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        auto_rsp = 1'b1;
        chk1("sq_vld", inst_valid, 1'b0);
        chk1("sq_req", imem_req, 1'b1);
        chk("sq_addr", imem_addr, 32'h0040_0000);
        fetch_one(32'h0040_0000);

        // Taken branch with rvalid in the redirect cycle.
        tick();
        redirect     = 1'b1;
        redirect_sel = 2'b01;
        br_taken     = 1'b1;
        br_off       = 16'hFFFF;
        redir_pc4    = 32'h0040_0010;
        tick();
        clear_redirect();
        chk1("bt_vld", inst_valid, 1'b0);
        chk1("bt_req", imem_req, 1'b1);
        chk("bt_addr", imem_addr, 32'h0040_000C);

        // Not-taken branch while REQ is not granted.
        imem_gnt     = 1'b0;
        redirect     = 1'b1;
        redirect_sel = 2'b01;
        br_taken     = 1'b0;
        redir_pc4    = 32'h0040_0010;
        tick();
        clear_redirect();
        imem_gnt = 1'b1;
        chk1("bn_req", imem_req, 1'b1);
        chk("bn_addr", imem_addr, 32'h0040_0010);

        // Redirect and inst_ready together in HOLD.
        tick();
        tick();
        chk1("hr_vld", inst_valid, 1'b1);
        chk("hr_pc", inst_pc, 32'h0040_0010);
        redirect     = 1'b1;
        redirect_sel = 2'b10;
        rs_data      = 32'h0040_0100;
        tick();
        clear_redirect();
        chk1("hr_drop", inst_valid, 1'b0);
        chk1("hr_req", imem_req, 1'b1);
        chk("hr_addr", imem_addr, 32'h0040_0100);
        tick();
        tick();
        chk("hr_inst", inst, 32'hBEEF_0100);
        chk("hr_newpc", inst_pc, 32'h0040_0100);
        chk("hr_newpc4", inst_pc4, 32'h0040_0104);
        tick();

        // Redirect coinciding with a grant in REQ.
        chk("rg_addr0", imem_addr, 32'h0040_0104);
        redirect     = 1'b1;
        redirect_sel = 2'b11;
        jmp_imm      = 26'h010_0008;
        redir_pc4    = 32'h0040_0108;
        tick();
        clear_redirect();
        chk1("rg_wait_req", imem_req, 1'b0);
        chk1("rg_wait_vld", inst_valid, 1'b0);
        tick();
        chk1("rg_vld", inst_valid, 1'b0);
        fetch_one(32'h0040_0020);

        // Halt: in-flight request completes, then no new request.
        halt = 1'b1;
        chk1("ht_req", imem_req, 1'b1);
        tick();
        tick();
        chk1("ht_vld", inst_valid, 1'b1);
        chk("ht_pc", inst_pc, 32'h0040_0024);
        tick();
        chk1("ht_idle_req", imem_req, 1'b0);
        chk1("ht_idle_vld", inst_valid, 1'b0);
        tick();
        chk1("ht_idle_req2", imem_req, 1'b0);
        halt = 1'b0;
        tick();
        chk1("ht_resume_req", imem_req, 1'b1);
        chk("ht_resume_addr", imem_addr, 32'h0040_0028);

        // Misaligned register target.
        imem_gnt     = 1'b0;
        redirect     = 1'b1;
        redirect_sel = 2'b10;
        rs_data      = 32'h0040_0006;
        tick();
        clear_redirect();
        imem_gnt = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
        chk1("al_fault", fetch_fault, 1'b1);
        chk1("al_vld", inst_valid, 1'b1);
        chk("al_inst", inst, 32'h0000_000C);
        chk("al_pc", inst_pc, 32'h0040_0006);
        chk1("al_noreq", imem_req, 1'b0);
        inst_ready = 1'b0;
        tick();
        chk1("al_fault_hold", fetch_fault, 1'b1);
        chk1("al_noreq2", imem_req, 1'b0);
        inst_ready = 1'b1;
        tick();
        chk1("al_fault_clr", fetch_fault, 1'b0);
        tick();
`else
        chk1("al_req", imem_req, 1'b1);
        chk("al_addr", imem_addr, 32'h0040_0004);
        tick();
`endif

        // Reset in WAIT; a late rvalid afterwards must be ignored.
        chk1("mr_wait_req", imem_req, 1'b0);
        rst_b = 1'b0;
        #1;
        chk1("mr_req", imem_req, 1'b0);
        chk("mr_addr", imem_addr, RPC);
        chk1("mr_vld", inst_valid, 1'b0);
        chk("mr_inst", inst, 32'h0);
        @(posedge clk);
        #1 rst_b = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        chk1("late_vld", inst_valid, 1'b0);
        chk("late_inst", inst, 32'h0);
        chk1("late_req", imem_req, 1'b1);
        chk("late_addr", imem_addr, RPC);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
